// File: rtl/ex_data_unpacker.sv
// Unpacks DATA_W-bit show-ahead FIFO words into PIX_W-bit pixels on a valid/ready
// stream, tagging start-of-frame and end-of-line from an active-window x/y counter.
module ex_data_unpacker #(
    parameter int DATA_W   = 32,
    parameter int PIX_W    = 16,
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int CNT_W    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_vld,
    output logic              fifo_rd_en,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              frame_done,
    output logic              busy,
    output logic              start_err
);

    localparam int PPW         = DATA_W / PIX_W;
    localparam int TOTAL_WORDS = H_ACTIVE * V_ACTIVE / PPW;
    localparam int WC_W        = $clog2(TOTAL_WORDS + 1);
    localparam int SEL_W       = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [WC_W-1:0]  WORDS_MAX = WC_W'(TOTAL_WORDS);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(PPW - 1);
    localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(V_ACTIVE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_vld;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_x;
    logic [CNT_W-1:0]  r_y;
    logic [WC_W-1:0]   r_words;
    logic              r_done;
    logic              r_start_err;

    logic              w_accept;
    logic              w_last_accept;
    logic              w_final;
    logic              w_rd_en;
    logic              w_pop;
    logic [PIX_W-1:0]  w_pix;

    // r_hold_vld is only ever set in RUN, so it alone qualifies the output stream.
    assign w_accept      = r_hold_vld & pix_ready;
    assign w_last_accept = w_accept & (r_sel == SEL_LAST);
    assign w_final       = w_accept & (r_x == X_LAST) & (r_y == Y_LAST);
    assign w_rd_en       = (r_state == ST_RUN) & (r_words < WORDS_MAX)
                         & (~r_hold_vld | w_last_accept);
    assign w_pop         = w_rd_en & fifo_rd_vld;

    always_comb begin
        w_pix = '0;
        for (int unsigned i = 0; i < PPW; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_pix = r_hold[i*PIX_W +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_vld  <= 1'b0;
            r_sel       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_words     <= '0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state    <= ST_RUN;
                        r_hold_vld <= 1'b0;
                        r_sel      <= '0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_words    <= '0;
                    end
                end
                ST_RUN: begin
                    if (frame_start) begin
                        r_start_err <= 1'b1;
                    end
                    if (w_accept) begin
                        r_sel <= w_last_accept ? '0 : r_sel + 1'b1;
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                    // A pop on the last-accept edge refills the hold register, so
                    // valid stays high across the word boundary.
                    if (w_pop) begin
                        r_hold     <= fifo_rd_data;
                        r_hold_vld <= 1'b1;
                        r_sel      <= '0;
                        r_words    <= r_words + 1'b1;
                    end else if (w_last_accept) begin
                        r_hold_vld <= 1'b0;
                    end
                    if (w_final) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign pix_data   = w_pix;
    assign pix_valid  = r_hold_vld;
    assign pix_sof    = r_hold_vld & (r_x == '0) & (r_y == '0);
    assign pix_eol    = r_hold_vld & (r_x == X_LAST);
    assign frame_done = r_done;
    assign busy       = (r_state == ST_RUN);
    assign start_err  = r_start_err;

endmodule

// File: doc/ex_data_unpacker.md
Name: ex_data_unpacker

Overview:
- Consumes 32-bit words from the show-ahead prefetch FIFO read port (valid/enable handshake) and splits each word into 16-bit pixels.
- Emits the pixels on a valid/ready stream tagged with start-of-frame and end-of-line, using an active-window counter.
- Sits directly downstream of the external-data prefetch FIFO, in front of the video processing pipeline.
- Sustains 1 pixel/cycle with no bubbles at word boundaries.

Parameters:
- DATA_W, 32, FIFO word width; must be an integer multiple of PIX_W.
- PIX_W, 16, pixel width (RGB565). PPW = DATA_W/PIX_W is derived.
- H_ACTIVE, 1280, pixels per line; must be a multiple of PPW.
- V_ACTIVE, 720, lines per frame.
- CNT_W, 12, width of the x and y counters; must hold max(H_ACTIVE, V_ACTIVE).

Ports:
- clk, in, 1, single clock, shared with the FIFO read side.
- rst_n, in, 1, asynchronous active-low reset.
- frame_start, in, 1, single-cycle pulse that arms one frame.
- fifo_rd_data, in, DATA_W, show-ahead word from the FIFO, valid while fifo_rd_vld=1.
- fifo_rd_vld, in, 1, FIFO has a word.
- fifo_rd_en, out, 1, ready to the FIFO; a pop occurs when fifo_rd_vld & fifo_rd_en.
- pix_data, out, PIX_W, pixel.
- pix_valid, out, 1, pixel valid.
- pix_ready, in, 1, downstream ready.
- pix_sof, out, 1, qualifies pixel (0,0) of the frame.
- pix_eol, out, 1, qualifies the last pixel of each line (x = H_ACTIVE-1).
- frame_done, out, 1, one-cycle pulse after the final pixel is accepted.
- busy, out, 1, high in RUN.
- start_err, out, 1, one-cycle pulse when frame_start arrives while in RUN.

Behaviour:
- Reset values: all outputs 0; state=IDLE; x=y=0; hold register empty; sub-index sel=0; word counter=0.
- State IDLE:
  - fifo_rd_en=0, pix_valid=0.
  - frame_start=1 moves to RUN next cycle and clears x, y, sel and the word counter.
- State RUN:
  - fifo_rd_en = (words_loaded < H_ACTIVE*V_ACTIVE/PPW) & (~hold_vld | last_accept).
  - last_accept = pix_valid & pix_ready & (sel == PPW-1).
  - On pop: the word is captured into the hold register and sel=0. The output is registered, so the word popped at edge N yields pix_valid=1 from cycle N+1.
  - pix_data = hold[sel*PIX_W +: PIX_W]. The low slice goes out first.
  - On pix_valid & pix_ready:
    - sel advances, wrapping at PPW-1.
    - x increments; at H_ACTIVE-1, x wraps to 0 and y increments.
  - When the last sub-pixel is accepted and no pop occurs the same edge, hold_vld clears and pix_valid drops.
  - Back-to-back: a last_accept and a pop on the same edge give continuous pix_valid.
- Stall: while pix_valid & ~pix_ready, pix_data, pix_sof, pix_eol, sel, x and y hold stable, and fifo_rd_en=0 if hold_vld.
- pix_sof = pix_valid & (x==0) & (y==0). pix_eol = pix_valid & (x==H_ACTIVE-1).
- FIFO empty (fifo_rd_vld=0): no pop and no error. Output bubbles only after the hold register drains.
- End of frame:
  - Once words_loaded reaches the total, fifo_rd_en stays 0, even if fifo_rd_vld=1. Words of the next frame are never consumed early.
  - When pixel (H_ACTIVE-1, V_ACTIVE-1) is accepted, the next edge gives frame_done=1 for one cycle, state=IDLE, busy=0.
- frame_start in RUN is ignored for state and counters; it pulses start_err next cycle.
- frame_start in the same cycle that the final pixel is accepted: treated as RUN, so it is ignored and start_err pulses.
- Reset mid-frame returns immediately to reset values. The partially held word is discarded, and no frame_done is produced.
- Word counter width is ceil(log2(H_ACTIVE*V_ACTIVE/PPW + 1)).

Test Plan:
Test configuration: H_ACTIVE=4, V_ACTIVE=2, PPW=2, 4 words per frame.
- Reset, then frame_start. FIFO holds 0xBBBBAAAA, 0xDDDDCCCC, 0x22221111, 0x44443333; pix_ready=1.
  - Pixels AAAA, BBBB, CCCC, DDDD, 1111, 2222, 3333, 4444 appear on consecutive cycles.
  - pix_sof on AAAA only; pix_eol on DDDD and 4444.
  - frame_done 1 cycle after 4444; 4 pops total.
- Same frame, pix_ready toggling 1,0,1,0: each pixel is held stable during ready=0, with no loss or duplication. fifo_rd_en=0 while the hold register is pending.
- FIFO with 6 words, one frame: exactly 4 pops. fifo_rd_en=0 afterwards while fifo_rd_vld=1; 2 words remain in the FIFO.
- fifo_rd_vld dropped for 3 cycles after word 2: pix_valid drops after CCCC/DDDD drain, then resumes with 1111; x, y and pix_eol stay correct.
- frame_start pulsed mid-frame: start_err pulses once; output sequence unchanged.
- rst_n asserted after 3 pixels: all outputs 0 immediately. A new frame_start then replays from pix_sof with the next FIFO word.
